alu_result_fifo: RTL and testbench
==================================

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the result data width, matching the ALU datapath.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the entry count; legal values are powers of 2 that are 2 or greater.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the ALU result presented this cycle.
REQ-006 The block SHALL have port in_result, input, WIDTH bits: the ALU result value.
REQ-007 The block SHALL have port in_zero, input, 1 bit: the ALU zero flag for in_result.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the FIFO can accept an entry this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-010 The block SHALL have port out_result, output, WIDTH bits: the head entry result.
REQ-011 The block SHALL have port out_zero, output, 1 bit: the head entry zero flag.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head this cycle.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the current occupancy, 0..DEPTH.
REQ-014 The block SHALL have port zero_count, output, 16 bits: the number of accepted entries with in_zero=1, saturating.
REQ-015 The block SHALL have port drop_flag, output, 1 bit: sticky, set when a presented result was discarded.

Function
REQ-016 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL equal (count != DEPTH), combinational from registered state only, with no dependence on out_ready.
REQ-018 out_valid SHALL equal (count != 0), with show-ahead behaviour: out_result/out_zero reflect the head entry whenever out_valid=1.
REQ-019 When out_valid=0, out_result and out_zero SHALL be don't-care, and the bench SHALL NOT check them.
REQ-020 Latency: an entry pushed at edge N SHALL be visible on out_* with out_valid=1 in the cycle after edge N; there is no same-cycle input-to-output pass-through.
REQ-021 Storage SHALL be DEPTH entries of {in_zero, in_result}, with write and read pointers incrementing modulo DEPTH (wrap from DEPTH-1 to 0).
REQ-022 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance; this is legal at any occupancy where in_ready=1.
REQ-023 When full (count=DEPTH), a pop with in_valid=1 SHALL NOT accept the input that cycle; in_ready is 0 throughout.
REQ-024 Count update SHALL be: +1 on push only, -1 on pop only, unchanged otherwise.
REQ-025 A pop when empty is impossible by construction, and the state SHALL be unchanged.
REQ-026 When in_valid=1 and in_ready=0, the entry SHALL be discarded (the ALU stage cannot stall) and drop_flag SHALL be set to 1 on that edge, remaining 1 until rst.
REQ-027 zero_count SHALL increment by 1 on each push with in_zero=1, saturate at 16'hFFFF, and never wrap.
REQ-028 Discarded entries SHALL NOT affect zero_count, count, or storage.

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL set count=0, both pointers=0, drop_flag=0, and zero_count=0, giving in_ready=1 and out_valid=0.
REQ-030 Reset SHALL take priority over a simultaneous push or pop; any in-flight entries SHALL be lost, and storage contents need not be cleared.
REQ-031 Reset asserted mid-operation (FIFO partially full) SHALL yield the REQ-029 state at the next edge, with normal operation starting on the first edge after rst deasserts.

Verification
REQ-032 The bench SHALL cover basic order: push 0x11,0x22,0x33 with out_ready=0, then out_ready=1, requiring a pop order of 0x11,0x22,0x33, count 3->0, and out_valid dropping after the third pop.
REQ-033 The bench SHALL cover fill and drop: 5 consecutive pushes with DEPTH=4 and out_ready=0, requiring count=4, in_ready=0 after the 4th, the 5th discarded, and drop_flag=1 sticky.
REQ-034 The bench SHALL cover wrap-around: 10 pushes interleaved with pops keeping count 1..3, requiring the output sequence to equal the input sequence exactly across pointer wrap.
REQ-035 The bench SHALL cover simultaneous push/pop: at count=2, push 0xA5 and pop in the same cycle, requiring count to stay 2 and 0xA5 to emerge after the two older entries.
REQ-036 The bench SHALL cover zero flag: push results 0,5,0 with in_zero=1,0,1, requiring zero_count=2 and out_zero popping 1,0,1; with zero_count preset near max, it saturates at 0xFFFF.
REQ-037 The bench SHALL cover reset mid-operation: at count=3 with drop_flag=1, pulse rst for 1 cycle, requiring count=0, out_valid=0, in_ready=1, drop_flag=0, and zero_count=0 on the next cycle.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: show-ahead FIFO buffering ALU results with zero flags.
// Rev 1.0 -- overflow drops the entry and sets a sticky flag; zero_count saturates.
`default_nettype none

module alu_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_zero,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_zero,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              zero_count,
  output logic                     drop_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic [WIDTH:0]  head;

  assign in_ready   = (count != FULL_COUNT);
  assign out_valid  = (count != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign head       = mem[rd_ptr];
  assign out_result = head[WIDTH-1:0];
  assign out_zero   = head[WIDTH];

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_zero, in_result};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      zero_count <= '0;
      drop_flag  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && in_zero && (zero_count != 16'hFFFF)) begin
        zero_count <= zero_count + 16'd1;
      end
      // The ALU stage cannot stall, so an unaccepted result is lost.
      if (in_valid && !in_ready) begin
        drop_flag <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
// Scoreboard testbench for alu_result_fifo (WIDTH=32, DEPTH=4).
`default_nettype none

module tb_alu_result_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [WIDTH-1:0]  in_result;
  logic              in_zero;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_result;
  logic              out_zero;
  logic              out_ready;
  logic [2:0]        count;
  logic [15:0]       zero_count;
  logic              drop_flag;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_result(in_result), .in_zero(in_zero), .in_ready(in_ready),
    .out_valid(out_valid), .out_result(out_result), .out_zero(out_zero), .out_ready(out_ready),
    .count(count), .zero_count(zero_count), .drop_flag(drop_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT performs is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual=0x%0h required=none", out_result);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_result", out_result, mon_e[31:0]);
        check("pop_zero", {31'b0, out_zero}, {31'b0, mon_e[32]});
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic z,
                       input logic ordy, input bit accept);
    in_valid  = v;
    in_result = d;
    in_zero   = z;
    out_ready = ordy;
    if (accept) exp_q.push_back({z, d});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_drop", drop_flag, 0);
    check("rst_zero_count", zero_count, 0);

    // Basic order and one-cycle latency
    drive(1, 32'h11, 0, 0, 1);
    check("lat_valid", out_valid, 1);
    check("lat_result", out_result, 32'h11);
    drive(1, 32'h22, 0, 0, 1);
    drive(1, 32'h33, 0, 0, 1);
    check("basic_count3", count, 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      check("basic_drain_count", count, 32'(2 - i));
    end
    check("basic_out_valid", out_valid, 0);
    check("basic_q_empty", exp_q.size(), 0);

    // Fill and drop; the dropped entry carries in_zero=1 and must not count
    for (int i = 0; i < 4; i++) drive(1, 32'h100 + 32'(i), 0, 0, 1);
    check("fill_count4", count, 4);
    check("fill_in_ready", in_ready, 0);
    check("fill_drop_before", drop_flag, 0);
    drive(1, 32'h1FF, 1, 0, 0);
    check("drop_count", count, 4);
    check("drop_flag_set", drop_flag, 1);
    check("drop_zero_count", zero_count, 0);
    drive(1, 32'h999, 0, 1, 0);   // pop while full: input refused
    check("full_pop_count", count, 3);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    check("fill_drained", count, 0);
    check("drop_sticky", drop_flag, 1);

    // Wrap-around with occupancy held at 2
    drive(1, 32'h300, 0, 0, 1);
    check("wrap_count1", count, 1);
    drive(1, 32'h301, 0, 0, 1);
    for (int i = 2; i < 10; i++) begin
      drive(1, 32'h300 + 32'(i), 0, 1, 1);
      check("wrap_count2", count, 2);
    end
    drive(0, 0, 0, 1, 0);
    check("wrap_count_tail", count, 1);
    drive(0, 0, 0, 1, 0);
    check("wrap_empty", out_valid, 0);
    check("wrap_q_empty", exp_q.size(), 0);

    // Simultaneous push/pop at count 2
    drive(1, 32'hA1, 0, 0, 1);
    drive(1, 32'hA2, 0, 0, 1);
    drive(1, 32'hA5, 0, 1, 1);
    check("sim_count2", count, 2);
    drive(0, 0, 0, 1, 0);
    check("sim_count1", count, 1);
    check("sim_head_a5", out_result, 32'hA5);
    drive(0, 0, 0, 1, 0);
    check("sim_empty", count, 0);

    // Zero flag accounting
    drive(1, 32'h0, 1, 0, 1);
    drive(1, 32'h5, 0, 0, 1);
    drive(1, 32'h0, 1, 0, 1);
    check("zero_count2", zero_count, 2);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    check("zero_drained", count, 0);

    // Reset mid-operation at count 3 with drop_flag set, push pending
    drive(1, 32'h41, 0, 0, 1);
    drive(1, 32'h42, 0, 0, 1);
    drive(1, 32'h43, 0, 0, 1);
    check("mid_count3", count, 3);
    rst = 1'b1;
    exp_q.delete();
    drive(1, 32'h55, 1, 0, 0);
    rst = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_drop", drop_flag, 0);
    check("mid_rst_zero_count", zero_count, 0);
    drive(1, 32'h77, 0, 0, 1);
    check("post_rst_head", out_result, 32'h77);
    drive(0, 0, 0, 1, 0);

    // zero_count saturation: stream zero-flagged results through the FIFO
    for (int i = 0; i < 65537; i++) begin
      drive(1, 32'(i), 1, 1, 1);
      if (i == 65533) check("zero_count_fffe", zero_count, 32'hFFFE);
    end
    check("zero_count_sat", zero_count, 32'hFFFF);
    check("sat_count1", count, 1);
    drive(0, 0, 0, 1, 0);
    check("sat_drained", count, 0);
    check("final_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
